// File: rtl/bus_pkg.sv
// Shared definitions for the inter-PE bus: sizing helpers and the
// slice-index functions for the packed per-PE vectors.
`default_nettype none

package bus_pkg;

   localparam int DEF_NUM_STAGES = 3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Round trip of a grant: out through the pipeline, PE deasserts, back again.
   function automatic int holdoff_cycles(input int stages);
      return 2 * stages + 1;
   endfunction

   function automatic int pe_slice_lsb(input int pe, input int width);
      return pe * width;
   endfunction

   function automatic int full_bit(input int dest, input int src, input int num_pe);
      return dest * num_pe + src;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// Combinational round-robin picker: first eligible source after ptr wins.
`default_nettype none

module bus_rr_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_PE = 8,
   parameter int IDX_W  = (clog2(NUM_PE) < 1) ? 1 : clog2(NUM_PE)
) (
   input  logic [NUM_PE-1:0] elig,
   input  logic [IDX_W-1:0]  ptr,
   output logic              gnt_valid,
   output logic [IDX_W-1:0]  gnt_idx
);

   // Scan from the farthest candidate back toward ptr+1 so the nearest
   // eligible source is the last one written and therefore wins.
   always_comb begin
      int cand;
      cand      = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = NUM_PE; i >= 1; i--) begin
         cand = (int'(ptr) + i) % NUM_PE;
         if (elig[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pe_bus_arbiter.sv
// Central arbiter for the shared inter-PE bus: one round-robin grant per
// cycle, per-source holdoff masking, registered bus outputs.
`default_nettype none

module pe_bus_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_PE       = 8,
   parameter int DATA_LEN     = 16,
   parameter int BUS_ADDR_LEN = 3,
   parameter int NUM_STAGES   = DEF_NUM_STAGES,
   parameter int HOLDOFF      = holdoff_cycles(NUM_STAGES)
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [BUS_ADDR_LEN*NUM_PE-1:0] i_addr_to_bus_p,
   input  logic [DATA_LEN*NUM_PE-1:0]     i_data_to_bus_p,
   input  logic [NUM_PE-1:0]              i_valid_to_bus_p,
   input  logic [NUM_PE*NUM_PE-1:0]       i_rd_buf_full_p,
   output logic [DATA_LEN-1:0]            data_bus,
   output logic [BUS_ADDR_LEN-1:0]        addr_bus,
   output logic [NUM_PE-1:0]              wr_to_bus,
   output logic [NUM_PE-1:0]              rd_from_bus,
   output logic                           o_err
);

   localparam int HOLD_W = (clog2(HOLDOFF + 1) < 1) ? 1 : clog2(HOLDOFF + 1);

   logic [BUS_ADDR_LEN-1:0] dest [NUM_PE];
   logic [HOLD_W-1:0]       hold_cnt [NUM_PE];
   logic [NUM_PE-1:0]       legal;
   logic [NUM_PE-1:0]       full_sel;
   logic [NUM_PE-1:0]       bad_req;
   logic [NUM_PE-1:0]       elig;
   logic [NUM_PE-1:0]       wr_next;
   logic [NUM_PE-1:0]       rd_next;
   logic [BUS_ADDR_LEN-1:0] ptr;
   logic [BUS_ADDR_LEN-1:0] gnt_idx;
   logic [BUS_ADDR_LEN-1:0] gnt_dest;
   logic                    gnt_valid;

   for (genvar s = 0; s < NUM_PE; s++) begin : g_src
      assign dest[s]    = i_addr_to_bus_p[pe_slice_lsb(s, BUS_ADDR_LEN) +: BUS_ADDR_LEN];
      assign legal[s]   = (int'(dest[s]) < NUM_PE) && (int'(dest[s]) != s);
      assign bad_req[s] = i_valid_to_bus_p[s] & ~legal[s];
      assign elig[s]    = i_valid_to_bus_p[s] & (hold_cnt[s] == '0) & legal[s] & ~full_sel[s];
   end

   // Full flag of the requested destination's buffer reserved for this source;
   // an illegal destination selects nothing and is masked by legal[] anyway.
   always_comb begin
      full_sel = '0;
      for (int s = 0; s < NUM_PE; s++) begin
         for (int d = 0; d < NUM_PE; d++) begin
            if (int'(dest[s]) == d) full_sel[s] = i_rd_buf_full_p[full_bit(d, s, NUM_PE)];
         end
      end
   end

   bus_rr_arbiter #(
      .NUM_PE (NUM_PE),
      .IDX_W  (BUS_ADDR_LEN)
   ) u_rr (
      .elig      (elig),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign gnt_dest = dest[gnt_idx];
   assign wr_next  = gnt_valid ? (NUM_PE'(1) << gnt_idx)  : '0;
   assign rd_next  = gnt_valid ? (NUM_PE'(1) << gnt_dest) : '0;

   // Holdoff counters: a fresh grant reloads, otherwise count down to zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < NUM_PE; s++) hold_cnt[s] <= '0;
      end else begin
         for (int s = 0; s < NUM_PE; s++) begin
            if (wr_next[s])
               hold_cnt[s] <= HOLD_W'(HOLDOFF);
            else if (hold_cnt[s] != '0)
               hold_cnt[s] <= hold_cnt[s] - HOLD_W'(1);
         end
      end
   end

   // Pointer starts at the last PE so PE0 is served first out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr         <= BUS_ADDR_LEN'(NUM_PE - 1);
         wr_to_bus   <= '0;
         rd_from_bus <= '0;
         data_bus    <= '0;
         addr_bus    <= '0;
         o_err       <= 1'b0;
      end else begin
         wr_to_bus   <= wr_next;
         rd_from_bus <= rd_next;
         if (gnt_valid) begin
            ptr      <= gnt_idx;
            addr_bus <= gnt_idx;
            data_bus <= i_data_to_bus_p[pe_slice_lsb(int'(gnt_idx), DATA_LEN) +: DATA_LEN];
         end
         if (|bad_req) o_err <= 1'b1;
      end
   end

endmodule

`default_nettype wire
